router_vc_input_buffer: RTL
===========================

Name: router_vc_input_buffer

Overview:
- Parametrised input-channel buffer for one mesh-router port (N, S, E, W or PE). Successor to the depth-1 channel buffer.
- Holds two virtual channels, even (VC0) and odd (VC1), each a FIFO of BUFFER_DEPTH flits.
- VCs are time-multiplexed by the global polarity signal: the link side writes one VC while the crossbar side drains the other, and the roles swap every cycle.
- Adds occupancy reporting and sticky drop detection.

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- BUFFER_DEPTH, 4, flits per VC; legal range 1..64; non-power-of-two values supported.
- CNT_W, $clog2(BUFFER_DEPTH+1), occupancy counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- polarity  in  1  global phase. 0 = write VC0 / read VC1; 1 = write VC1 / read VC0.
- si  in  1  upstream send: a flit is present on di this cycle.
- di  in  DATA_WIDTH  upstream flit.
- ro  out  1  ready to upstream; combinational.
- so  out  1  send to crossbar; registered.
- do  out  DATA_WIDTH  flit to crossbar; registered.
- ri  in  1  crossbar/downstream ready.
- occ_vc0  out  CNT_W  VC0 flit count; registered.
- occ_vc1  out  CNT_W  VC1 flit count; registered.
- err_drop  out  1  sticky: a flit was offered while ro=0.

Behaviour:
- Write VC: wv = polarity. Read VC: rv = ~polarity. wv and rv always differ, so a same-VC read/write collision cannot occur.
- ro = (occ[wv] != BUFFER_DEPTH). It is combinational from polarity and the counters.
- Write: at the rising edge with si=1 and ro=1:
  - mem[wv][wptr[wv]] <= di
  - wptr[wv] increments, wrapping BUFFER_DEPTH-1 -> 0
  - occ[wv] increments
- Drop: at the rising edge with si=1 and ro=0:
  - flit discarded; no state change in the FIFO
  - err_drop <= 1; it stays 1 until reset.
- Read: at the rising edge with ri=1 and occ[rv]!=0:
  - so <= 1, do <= mem[rv][rptr[rv]]
  - rptr[rv] wraps as above
  - occ[rv] decrements.
- Otherwise at each edge: so <= 0 and do holds its last value.
- so is high for exactly one cycle per flit. Downstream must sample do while so=1.
- Latency: a flit written at the edge where polarity=p can be read at the next edge, where polarity=~p, provided ri=1 and it is at the head. Result: so rises one cycle after the write edge.
- Ordering: strict FIFO within each VC. No ordering between VCs.
- Write and read in the same edge are independent; both VCs' counters may change at one edge.
- The polarity input must toggle every cycle. If it stalls, the block still behaves correctly on the wv/rv rule above, with no special handling.
- Full: occ[wv]=BUFFER_DEPTH forces ro=0.
- Empty: occ[rv]=0 suppresses the read; so=0 even when ri=1.
- BUFFER_DEPTH=1 reduces to the prior single-slot behaviour per VC.
- Reset (asynchronous assert, any time including mid-transfer):
  - all pointers and counters 0
  - so=0, do=0, err_drop=0
  - ro therefore reads 1
  - buffered flits are lost.
- Reset deassertion is synchronised externally. The first edge after deassertion is a normal cycle.

Test Plan:
- Reset, then polarity toggling with si=0 and ri=1 -> so=0, do=0, occ_vc0=occ_vc1=0, ro=1, err_drop=0 throughout.
- polarity=0 at edge E, si=1, di=64'hA5A5_0000_0000_0001, ri=1 -> at edge E+1 (polarity=1): so=1, do=64'hA5A5_0000_0000_0001, occ_vc0 1->0. At E+2: so=0.
- BUFFER_DEPTH=3, ri=0, push 3 flits into VC0 on polarity=0 cycles:
  - -> occ_vc0=3 and ro=0 on the next polarity=0 cycle
  - a 4th si=1 -> err_drop=1, occ_vc0 stays 3
  - then ri=1 -> the 3 flits exit in order on polarity=1 cycles.
- BUFFER_DEPTH=3, stream 10 flits into VC1 with ri=1 -> pointers wrap. All 10 exit in order with no drops; max occ_vc1 is 1.
- Interleave 4 flits per VC with ri=1 -> each VC preserves its own order. occ_vc0 and occ_vc1 update at the same edge without interference.
- Assert reset mid-stream with occ_vc0=2 and so=1 -> immediately so=0, do=0, occ=0, ro=1, err_drop=0. After release, the first new flit exits with 1-cycle latency.

Source files
------------

// File: rtl/router_vc_input_buffer.sv
// Two-VC router input buffer: link side writes VC[polarity], crossbar side drains VC[~polarity].
// Latency: a flit written at edge E reaches so/do at edge E+1 (next phase), with ri=1 and the flit at the head.
// Backpressure: ro is low while the write VC is full; a flit offered then is discarded and err_drop is set (sticky).

module router_vc_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0]      count
);
    // Callers only push when not full and pop when not empty.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST) ? '0 : wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= (rptr == LAST) ? '0 : rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the counters alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_dat;
        end
    end

    assign head_dat = mem[rptr];
endmodule

module router_vc_input_buffer #(
    parameter  int DATA_WIDTH   = 64,
    parameter  int BUFFER_DEPTH = 4,
    localparam int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  si,
    input  logic [DATA_WIDTH-1:0] di,
    output logic                  ro,
    output logic                  so,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  ri,
    output logic [CNT_W-1:0]      occ_vc0,
    output logic [CNT_W-1:0]      occ_vc1,
    output logic                  err_drop
);
    logic                  wv;
    logic                  rv;
    logic                  rd_ok;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [CNT_W-1:0]      occ  [2];
    logic [DATA_WIDTH-1:0] head [2];

    // wv and rv always differ, so one VC is never read and written at the same edge.
    assign wv    = polarity;
    assign rv    = ~polarity;
    assign ro    = (occ[wv] != CNT_W'(BUFFER_DEPTH));
    assign rd_ok = ri && (occ[rv] != '0);

    assign push[0] = si & ro & ~wv;
    assign push[1] = si & ro &  wv;
    assign pop[0]  = rd_ok & ~rv;
    assign pop[1]  = rd_ok &  rv;

    for (genvar v = 0; v < 2; v++) begin : g_vc
        router_vc_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BUFFER_DEPTH),
            .CNT_W      (CNT_W)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[v]),
            .push_dat (di),
            .pop      (pop[v]),
            .head_dat (head[v]),
            .count    (occ[v])
        );
    end

    assign occ_vc0 = occ[0];
    assign occ_vc1 = occ[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            so       <= 1'b0;
            dout     <= '0;
            err_drop <= 1'b0;
        end else begin
            so <= rd_ok;
            if (rd_ok) begin
                dout <= head[rv];
            end
            if (si && !ro) begin
                err_drop <= 1'b1;
            end
        end
    end
endmodule
